voice_allocator: RTL and testbench

- Arbitrates NUM_KEYS debounced button requesters onto NUM_VOICES shared square-wave voices.
- Each voice is one pwm instance.
- Per voice, drives period, compare (50% duty) and gate; the top level mixes these into the external DAC.
- Sits between the raw button pins and the pwm bank, replacing the fixed button-to-generator wiring.

---
 rtl/voice_allocator.sv | 273 +++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - debounced key to shared pwm voice allocator
//
// Purpose: synchronizes and debounces NUM_KEYS raw buttons. It queues one
// press/release event per key and assigns presses to NUM_VOICES square-wave
// voices. Each voice receives period, compare (50% duty) and gate.
//
// Optional feature: define VOICE_ALLOC_STEAL_EN to let a press steal the
// oldest voice when every voice is busy. When it is undefined, that press
// is dropped.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   key            raw asynchronous buttons, active high
//   key_period     per-key period words, key k at [k*CTR_SIZE +: CTR_SIZE]
//   voice_period   per-voice period words, same packing
//   voice_compare  per-voice compare words (period >> 1)
//   voice_gate     per-voice audible flag
//   voice_key      per-voice owning key index, 3 bits each
//   full_pulse     one-cycle pulse when a press found no free voice
module voice_allocator #(
    parameter int NUM_KEYS      = 5,
    parameter int NUM_VOICES    = 4,
    parameter int CTR_SIZE      = 24,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_KEYS-1:0]            key,
    input  logic [NUM_KEYS*CTR_SIZE-1:0]   key_period,
    output logic [NUM_VOICES*CTR_SIZE-1:0] voice_period,
    output logic [NUM_VOICES*CTR_SIZE-1:0] voice_compare,
    output logic [NUM_VOICES-1:0]          voice_gate,
    output logic [NUM_VOICES*3-1:0]        voice_key,
    output logic                           full_pulse
);
    localparam int KW = 3;
    localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_APPLY} state_t;

    // synchronizer and debounce
    logic [NUM_KEYS-1:0]      sync1, sync2, deb;
    logic [DEBOUNCE_BITS-1:0] cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0]      rise, fall;

    // pending events: pend_press=1 for press, 0 for release
    logic [NUM_KEYS-1:0]      pend, pend_press;

    state_t                   state, state_next;
    logic [KW-1:0]            sel_key;
    logic                     sel_press;
    logic [AW-1:0]            tgt_v;
    logic                     tgt_ok;
    logic                     sel_full;

    logic [CTR_SIZE-1:0]      per_r [NUM_VOICES];
    logic [CTR_SIZE-1:0]      cmp_r [NUM_VOICES];
    logic [KW-1:0]            vkey_r [NUM_VOICES];
    logic [NUM_VOICES-1:0]    gate_r;
    logic [AW-1:0]            age [NUM_VOICES];

    logic                     pick_found, pick_press;
    logic [KW-1:0]            pick_key;
    logic                     rel_found, free_found;
    logic [AW-1:0]            rel_v, free_v;
    logic [CTR_SIZE-1:0]      sel_period;
`ifdef VOICE_ALLOC_STEAL_EN
    logic [AW-1:0]            old_v;
`endif

    // The flip happens on the same edge that raises the pending bit.
    always_comb begin
        rise = '0;
        fall = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if ((sync2[k] != deb[k]) && (&cnt[k])) begin
                rise[k] = ~deb[k];
                fall[k] = deb[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (sync2[k] == deb[k]) begin
                    cnt[k] <= '0;
                end else if (&cnt[k]) begin
                    deb[k] <= ~deb[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + DEBOUNCE_BITS'(1);
                end
            end
        end
    end

    // A fresh edge beats the APPLY-cycle clear of the same key.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            pend_press <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (rise[k] || fall[k]) begin
                    pend[k]       <= 1'b1;
                    pend_press[k] <= rise[k];
                end else if (state == S_APPLY && sel_key == KW'(k)) begin
                    pend[k] <= 1'b0;
                end
            end
        end
    end

    // Releases first, then presses; the descending loop leaves the lowest index.
    always_comb begin
        pick_found = 1'b0;
        pick_press = 1'b0;
        pick_key   = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pend[k] && !pend_press[k]) begin
                pick_found = 1'b1;
                pick_key   = KW'(k);
            end
        end
        if (!pick_found) begin
            for (int k = NUM_KEYS - 1; k >= 0; k--) begin
                if (pend[k]) begin
                    pick_found = 1'b1;
                    pick_press = 1'b1;
                    pick_key   = KW'(k);
                end
            end
        end
    end

    always_comb begin
        rel_found  = 1'b0;
        rel_v      = '0;
        free_found = 1'b0;
        free_v     = '0;
`ifdef VOICE_ALLOC_STEAL_EN
        old_v      = '0;
`endif
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (gate_r[v] && vkey_r[v] == sel_key) begin
                rel_found = 1'b1;
                rel_v     = AW'(v);
            end
            if (!gate_r[v]) begin
                free_found = 1'b1;
                free_v     = AW'(v);
            end
`ifdef VOICE_ALLOC_STEAL_EN
            if (age[v] == AW'(NUM_VOICES - 1)) old_v = AW'(v);
`endif
        end
    end

    always_comb begin
        sel_period = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (sel_key == KW'(k)) sel_period = key_period[k*CTR_SIZE +: CTR_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        full_pulse = 1'b0;
        case (state)
            S_IDLE:   if (pick_found) state_next = S_SELECT;
            S_SELECT: state_next = S_APPLY;
            S_APPLY: begin
                state_next = S_IDLE;
                full_pulse = sel_full;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_key   <= '0;
            sel_press <= 1'b0;
            tgt_v     <= '0;
            tgt_ok    <= 1'b0;
            sel_full  <= 1'b0;
            gate_r    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                per_r[v]  <= '0;
                cmp_r[v]  <= '0;
                vkey_r[v] <= '0;
                age[v]    <= AW'(NUM_VOICES - 1 - v);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        sel_key   <= pick_key;
                        sel_press <= pick_press;
                    end
                end
                S_SELECT: begin
                    if (sel_press) begin
                        if (free_found) begin
                            tgt_v    <= free_v;
                            tgt_ok   <= 1'b1;
                            sel_full <= 1'b0;
                        end else begin
                            sel_full <= 1'b1;
`ifdef VOICE_ALLOC_STEAL_EN
                            tgt_v    <= old_v;
                            tgt_ok   <= 1'b1;
`else
                            tgt_ok   <= 1'b0;
`endif
                        end
                    end else begin
                        tgt_v    <= rel_v;
                        tgt_ok   <= rel_found;
                        sel_full <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (tgt_ok) begin
                        if (sel_press) begin
                            per_r[tgt_v]  <= sel_period;
                            cmp_r[tgt_v]  <= sel_period >> 1;
                            vkey_r[tgt_v] <= sel_key;
                            gate_r[tgt_v] <= 1'b1;
                            for (int v = 0; v < NUM_VOICES; v++) begin
                                if (AW'(v) == tgt_v)
                                    age[v] <= '0;
                                else if (age[v] < age[tgt_v])
                                    age[v] <= age[v] + AW'(1);
                            end
                        end else begin
                            gate_r[tgt_v] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        voice_period  = '0;
        voice_compare = '0;
        voice_key     = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_period[v*CTR_SIZE +: CTR_SIZE]  = per_r[v];
            voice_compare[v*CTR_SIZE +: CTR_SIZE] = cmp_r[v];
            voice_key[v*KW +: KW]                 = vkey_r[v];
        end
    end

    assign voice_gate = gate_r;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - self-checking bench for voice_allocator
module tb_voice_allocator;
    localparam int NK = 5;
    localparam int NV = 4;
    localparam int CW = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic [NK-1:0]      key;
    logic [NK*CW-1:0]   key_period;
    logic [NV*CW-1:0]   voice_period;
    logic [NV*CW-1:0]   voice_compare;
    logic [NV-1:0]      voice_gate;
    logic [NV*3-1:0]    voice_key;
    logic               full_pulse;

    int checks = 0;
    int errors = 0;
    int full_cnt = 0;
    int gate_seen = 0;

    voice_allocator #(
        .NUM_KEYS(NK), .NUM_VOICES(NV), .CTR_SIZE(CW), .DEBOUNCE_BITS(4)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .key_period(key_period),
        .voice_period(voice_period), .voice_compare(voice_compare),
        .voice_gate(voice_gate), .voice_key(voice_key), .full_pulse(full_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (full_pulse === 1'b1) full_cnt++;
        if (voice_gate !== '0) gate_seen = 1;
    end

    typedef struct {
        logic [NK-1:0]  key;
        logic [NV-1:0]  gate;
        logic [11:0]    vkey;
        int             pv;
        logic [CW-1:0]  per;
        logic [CW-1:0]  cmp;
        int             full;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key = '0;
        step(3);
        rst = 1'b0;
        full_cnt = 0;
        gate_seen = 0;
    endtask

    task automatic set_kp(input int k, input logic [CW-1:0] val);
        key_period[k*CW +: CW] = val;
    endtask

    function automatic logic [CW-1:0] vp(input int v);
        return voice_period[v*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] vc(input int v);
        return voice_compare[v*CW +: CW];
    endfunction

    function automatic logic [2:0] vk(input int v);
        return voice_key[v*3 +: 3];
    endfunction

    initial begin
        logic [11:0] mask;
        rst = 1'b1;
        key = '0;
        key_period = '0;

        // allocation table: kp0..4 = 4096, 3000, 2000, 1000, 5001
        vecs[0] = '{5'b00001, 4'b0001, 12'o0000, 0, 24'd4096, 24'd2048, 0};
        vecs[1] = '{5'b00011, 4'b0011, 12'o0010, 1, 24'd3000, 24'd1500, 0};
        vecs[2] = '{5'b00111, 4'b0111, 12'o0210, 2, 24'd2000, 24'd1000, 0};
        vecs[3] = '{5'b01111, 4'b1111, 12'o3210, 3, 24'd1000, 24'd500,  0};
`ifdef VOICE_ALLOC_STEAL_EN
        vecs[4] = '{5'b11111, 4'b1111, 12'o3214, 0, 24'd5001, 24'd2500, 1};
        vecs[5] = '{5'b11110, 4'b1111, 12'o3214, 0, 24'd5001, 24'd2500, 1};
        vecs[6] = '{5'b11100, 4'b1101, 12'o3204, 1, 24'd3000, 24'd1500, 1};
        vecs[7] = '{5'b11101, 4'b1111, 12'o3204, 1, 24'd4096, 24'd2048, 1};
        vecs[8] = '{5'b00000, 4'b0000, 12'o0000, 0, 24'd5001, 24'd2500, 1};
`else
        vecs[4] = '{5'b11111, 4'b1111, 12'o3210, 0, 24'd4096, 24'd2048, 1};
        vecs[5] = '{5'b11110, 4'b1110, 12'o3210, 0, 24'd4096, 24'd2048, 1};
        vecs[6] = '{5'b11100, 4'b1100, 12'o3200, 1, 24'd3000, 24'd1500, 1};
        vecs[7] = '{5'b11101, 4'b1101, 12'o3200, 0, 24'd4096, 24'd2048, 1};
        vecs[8] = '{5'b00000, 4'b0000, 12'o0000, 0, 24'd4096, 24'd2048, 1};
`endif

        // idle after reset
        do_reset();
        step(100);
        check("idle gate_seen", 64'(gate_seen), 64'd0);
        check("idle full_cnt", 64'(full_cnt), 64'd0);
        check("idle period", 64'(voice_period), 64'd0);
        check("idle compare", 64'(voice_compare), 64'd0);
        check("idle voice_key", 64'(voice_key), 64'd0);

        // exact press latency and release
        set_kp(2, 24'd4096);
        key = 5'b00100;
        step(20);
        check("latency gate early", 64'(voice_gate), 64'd0);
        step(1);
        check("latency gate", 64'(voice_gate), 64'b0001);
        check("latency period", 64'(vp(0)), 64'd4096);
        check("latency compare", 64'(vc(0)), 64'd2048);
        check("latency key", 64'(vk(0)), 64'd2);
        key = '0;
        step(40);
        check("release gate", 64'(voice_gate), 64'd0);
        check("release period kept", 64'(vp(0)), 64'd4096);

        // bouncing key never debounces
        gate_seen = 0;
        for (int i = 0; i < 40; i++) begin
            key = (i % 2 == 0) ? 5'b00100 : 5'b00000;
            step(5);
        end
        key = '0;
        step(40);
        check("bounce gate_seen", 64'(gate_seen), 64'd0);

        // key pressed while reset is held
        rst = 1'b1;
        step(10);
        key = 5'b00001;
        step(30);
        check("rst held gate", 64'(voice_gate), 64'd0);
        rst = 1'b0;
        full_cnt = 0;
        step(20);
        check("post-rst gate early", 64'(voice_gate), 64'd0);
        step(1);
        check("post-rst gate", 64'(voice_gate), 64'b0001);
        key = '0;

        // allocation table
        do_reset();
        set_kp(0, 24'd4096);
        set_kp(1, 24'd3000);
        set_kp(2, 24'd2000);
        set_kp(3, 24'd1000);
        set_kp(4, 24'd5001);
        for (int r = 0; r < 9; r++) begin
            key = vecs[r].key;
            step(40);
            mask = '0;
            for (int v = 0; v < NV; v++) if (vecs[r].gate[v]) mask[v*3 +: 3] = 3'b111;
            check($sformatf("row%0d gate", r), 64'(voice_gate), 64'(vecs[r].gate));
            check($sformatf("row%0d voice_key", r), 64'(voice_key & mask), 64'(vecs[r].vkey & mask));
            check($sformatf("row%0d period", r), 64'(vp(vecs[r].pv)), 64'(vecs[r].per));
            check($sformatf("row%0d compare", r), 64'(vc(vecs[r].pv)), 64'(vecs[r].cmp));
            check($sformatf("row%0d full_cnt", r), 64'(full_cnt), 64'(vecs[r].full));
        end

        // release and press debounced in the same cycle
        do_reset();
        set_kp(0, 24'd4096);
        set_kp(1, 24'd3000);
        set_kp(4, 24'd5001);
        key = 5'b00011;
        step(40);
        check("same setup gate", 64'(voice_gate), 64'b0011);
        key = 5'b10001;
        step(21);
        check("same release first", 64'(voice_gate), 64'b0001);
        step(3);
        check("same press gate", 64'(voice_gate), 64'b0011);
        check("same press key", 64'(vk(1)), 64'd4);
        check("same press period", 64'(vp(1)), 64'd5001);

        // period latched while sounding
        set_kp(0, 24'd8192);
        step(10);
        check("latched period", 64'(vp(0)), 64'd4096);
        key = 5'b10000;
        step(40);
        check("latch release gate", 64'(voice_gate), 64'b0010);
        key = 5'b10001;
        step(40);
        check("repress gate", 64'(voice_gate), 64'b0011);
        check("repress period", 64'(vp(0)), 64'd8192);
        check("repress compare", 64'(vc(0)), 64'd4096);
        check("repress full_cnt", 64'(full_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
